// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and default sizing for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational tie-break; a tie goes to the requester that did not own the port last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  owner_t last_owner,
  output owner_t own,
  output logic   vld
);
  assign vld = if_req | dm_req;
  assign own = (if_req && dm_req) ? ((last_owner == OWN_IF) ? OWN_DM : OWN_IF)
             : (dm_req ? OWN_DM : OWN_IF);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise data always wins a tie.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);
  state_t state_q, state_d;
  owner_t owner_q, owner_d, pick_own, last_owner;
  logic pick_vld;
  logic if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d, if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, err_q, err_d, busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [7:0] cnt_q, cnt_d;
  mem_arb_pick u_pick (
    .if_req(if_req), .dm_req(dm_req), .last_owner(last_owner), .own(pick_own), .vld(pick_vld)
  );
`ifdef MEM_ARB_RR_EN
  owner_t last_owner_q, last_owner_d;
  always_comb last_owner_d = (state_q == IDLE && pick_vld) ? pick_own : last_owner_q;
  always_ff @(posedge clk) last_owner_q <= rst ? OWN_IF : last_owner_d;
  assign last_owner = last_owner_q;
`else
  // Pretending fetch always owned last makes every tie go to data.
  assign last_owner = OWN_IF;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    mem_en_d = mem_en_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    if_gnt_d = 1'b0;
    dm_gnt_d = 1'b0;
    if_done_d = 1'b0;
    dm_done_d = 1'b0;
    if (state_q == IDLE && pick_vld) begin
      state_d = ACCESS;
      owner_d = pick_own;
      cnt_d = 8'd1;
      mem_en_d = 1'b1;
      mem_we_d = (pick_own == OWN_DM) && dm_we;
      mem_addr_d = (pick_own == OWN_DM) ? dm_addr : if_addr;
      mem_wdata_d = (pick_own == OWN_DM) ? dm_wdata : '0;
      if_gnt_d = pick_own == OWN_IF;
      dm_gnt_d = pick_own == OWN_DM;
    end else if (state_q == ACCESS && (mem_ready || cnt_q == 8'(TIMEOUT))) begin
      // A ready on the timeout cycle still counts as a successful access.
      state_d = RESP;
      mem_en_d = 1'b0;
      mem_we_d = 1'b0;
      rdata_d = mem_ready ? mem_rdata : '0;
      err_d = !mem_ready;
      if_done_d = owner_q == OWN_IF;
      dm_done_d = owner_q == OWN_DM;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q + 8'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      cnt_q <= '0;
      if_gnt_q <= 1'b0;
      dm_gnt_q <= 1'b0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      if_gnt_q <= if_gnt_d;
      dm_gnt_q <= dm_gnt_d;
      if_done_q <= if_done_d;
      dm_done_q <= dm_done_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
  end
  assign if_gnt = if_gnt_q;
  assign dm_gnt = dm_gnt_q;
  assign if_done = if_done_q;
  assign dm_done = dm_done_q;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata = rdata_q;
  assign err = err_q;
  assign busy = busy_q;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 16, maximum ACCESS cycles before abort (range 1..255).
REQ-002 Reset SHALL be rst, synchronous, active-high; clock SHALL be clk.
REQ-003 Ports SHALL be as follows, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse, fetch access started
- if_done  out  1  one-cycle pulse, fetch data valid
- dm_req  in  1  data request, held until dm_done
- dm_we  in  1  data write enable
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse, data access started
- dm_done  out  1  one-cycle pulse, data access complete
- rdata  out  DATA_W  read data, valid with if_done or dm_done
- err  out  1  timeout flag, valid with if_done or dm_done
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes access this cycle
- busy  out  1  state is not IDLE

Function
REQ-004 The FSM SHALL have three states, IDLE, ACCESS and RESP, with registered outputs only.
REQ-005 In IDLE, when any request is high at a clock edge, the FSM SHALL latch the owner, address, we (0 for fetch) and wdata, then enter ACCESS.
REQ-006 In the first ACCESS cycle the FSM SHALL pulse the owner's gnt for exactly one cycle.
REQ-007 In ACCESS, mem_en SHALL be 1, and mem_we, mem_addr and mem_wdata SHALL be driven from the latched values, stable until exit.
REQ-008 If mem_ready is sampled at 1 in ACCESS, the FSM SHALL capture mem_rdata into rdata, clear err and enter RESP.
REQ-009 An ACCESS cycle counter SHALL start at 1 on entry; if the counter equals TIMEOUT and mem_ready is 0, the FSM SHALL set rdata to 0, set err to 1 and enter RESP.
REQ-010 If mem_ready and the timeout occur in the same cycle, mem_ready SHALL win (err=0).
REQ-011 In RESP, the owner's done SHALL be pulsed for one cycle, with rdata and err held until the next RESP; the FSM SHALL then return to IDLE.
REQ-012 Minimum latency SHALL be: request seen at edge N, gnt in cycle N+1, done in cycle N+2 when mem_ready=1 immediately; throughput SHALL be at most one access per 3 cycles.
REQ-013 Deassertion of a request during ACCESS or RESP SHALL NOT abort the access; it SHALL complete and done SHALL still pulse.
REQ-014 Tie-break when both requests are high in IDLE SHALL follow REQ-017/018.
REQ-015 For writes, rdata SHALL be updated with mem_rdata, whose value is don't-care.

Reset
REQ-016 rst SHALL force:
- state to IDLE
- all gnt/done pulses, mem_en, mem_we, err and busy to 0
- mem_addr, mem_wdata and rdata to 0
- the counter to 0 and last_owner to IF
rst mid-ACCESS SHALL abort the access without a done pulse.

Configuration
REQ-017 With MEM_ARB_RR_EN defined, a tie SHALL be granted to the requester not equal to last_owner, with last_owner updated on each grant; the first tie after reset SHALL therefore go to data.
REQ-018 Without MEM_ARB_RR_EN, a tie SHALL always be granted to data (fixed priority), and the last_owner register SHALL be absent.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the owner enum (OWN_IF/OWN_DM) and the default width and timeout constants.
REQ-020 One sub-module, mem_arb_pick, SHALL be used: a combinational tie-break taking if_req, dm_req and last_owner, and producing the grant owner and a valid flag.

Verification
REQ-021 Single fetch: if_req=1 with if_addr=0x0000_0040, mem_ready=1 immediately, mem_rdata=0x8C01_0004 -> if_gnt in cycle 1, if_done in cycle 2, rdata=0x8C01_0004, err=0.
REQ-022 Store with wait states: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF, mem_ready after 3 cycles -> mem_en high for 3 cycles, mem_we=1, mem_addr=0x100, then dm_done.
REQ-023 Tie: if_req=dm_req=1 held for 2 accesses -> with MEM_ARB_RR_EN, dm is granted then if; without it, dm is granted then dm.
REQ-024 Timeout: TIMEOUT=4, mem_ready=0 permanently -> exactly 4 ACCESS cycles, then done with err=1 and rdata=0; a ready arriving on cycle 4 -> err=0.
REQ-025 Reset mid-access: rst asserted during the 2nd ACCESS cycle -> next cycle IDLE, mem_en=0, no done, busy=0.
REQ-026 Request dropped: dm_req deasserted after dm_gnt -> access completes and dm_done still pulses.
